simple22_loader: RTL and testbench



---
 rtl/simple22_loader_if.sv | 32 +++
 rtl/simple22_loader.sv | 202 ++++++++++++++++++++
 tb/tb_simple22_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/simple22_loader_if.sv
// Byte-in / program-load bus between the UART receiver, simple22_loader and the Simple22 core.
// master: the loader (consumes bytes, drives the core's load and run-control inputs).
// slave:  the surrounding system (supplies bytes, observes the core-side signals).
interface simple22_loader_if #(
    parameter int unsigned ISIZE = 32,
    parameter int unsigned RSIZE = 24
);
    logic [7:0]       i_byte;
    logic             i_byte_valid;
    logic [ISIZE-1:0] new_instruction;
    logic [RSIZE-1:0] final_pc;
    logic             new_instruction_available;
    logic             execute;

    modport master (
        input  i_byte,
        input  i_byte_valid,
        output new_instruction,
        output final_pc,
        output new_instruction_available,
        output execute
    );

    modport slave (
        output i_byte,
        output i_byte_valid,
        input  new_instruction,
        input  final_pc,
        input  new_instruction_available,
        input  execute
    );
endinterface

// File: rtl/simple22_loader.sv
// Program loader and run controller for the Simple22 core.
// Assembles little-endian 32-bit words from a UART byte stream, writes them into
// instruction memory through a strobed interface, and gates execution.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte).
module simple22_loader #(
    parameter int unsigned IMEM_DEPTH    = 256,
    parameter int unsigned STROBE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    simple22_loader_if.master         bus,
    output logic                      o_busy,
    output logic                      o_error
);
    localparam int unsigned RSIZE = 24;
    localparam int unsigned SCW   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h5A;
    localparam logic [7:0] CMD_STOP = 8'hC3;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RUN
    } state_t;

    state_t           state, next_state;
    logic [31:0]      word;
    logic [1:0]       byte_cnt;
    logic [7:0]       k;
    logic [7:0]       n;
    logic [SCW-1:0]   strobe_cnt;
    logic             loaded;

    logic err_set, err_clr, loaded_set, loaded_clr;
    logic byte_shift, word_done, n_load, k_inc, k_clr;
    logic strobe_clr, strobe_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_load, csum_xor;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode and datapath control strobes
    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        loaded_set = 1'b0;
        loaded_clr = 1'b0;
        byte_shift = 1'b0;
        word_done  = 1'b0;
        n_load     = 1'b0;
        k_inc      = 1'b0;
        k_clr      = 1'b0;
        strobe_clr = 1'b0;
        strobe_inc = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_load  = 1'b0;
        csum_xor   = 1'b0;
`endif
        case (state)
            IDLE, RUN: begin
                if (bus.i_byte_valid) begin
                    if (bus.i_byte == CMD_LOAD) begin
                        next_state = COUNT;
                        err_clr    = 1'b1;
                        loaded_clr = 1'b1;
                        k_clr      = 1'b1;
                    end else if (state == IDLE && bus.i_byte == CMD_RUN) begin
                        if (loaded) next_state = RUN;
                        else        err_set    = 1'b1;
                    end else if (state == RUN && bus.i_byte == CMD_STOP) begin
                        next_state = IDLE;
                    end
                end
            end
            COUNT: begin
                if (bus.i_byte_valid) begin
                    if (bus.i_byte == 8'd0 || {24'd0, bus.i_byte} > IMEM_DEPTH) begin
                        err_set    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        n_load     = 1'b1;
                        next_state = DATA;
`ifdef LOADER_CHECKSUM_EN
                        csum_load  = 1'b1;
`endif
                    end
                end
            end
            DATA: begin
                if (bus.i_byte_valid) begin
                    byte_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_xor   = 1'b1;
`endif
                    if (byte_cnt == 2'd3) begin
                        word_done  = 1'b1;
                        next_state = WR_SETUP;
                    end
                end
            end
            WR_SETUP, WR_STROBE, WR_HOLD: begin
                if (bus.i_byte_valid) begin
                    // A byte arriving mid-write means the sender outran us; abandon the program.
                    err_set    = 1'b1;
                    loaded_clr = 1'b1;
                    next_state = IDLE;
                end else if (state == WR_SETUP) begin
                    strobe_clr = 1'b1;
                    next_state = WR_STROBE;
                end else if (state == WR_STROBE) begin
                    if (strobe_cnt == SCW'(STROBE_CYCLES - 1)) next_state = WR_HOLD;
                    else                                       strobe_inc = 1'b1;
                end else if (k == n - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = CSUM;
`else
                    loaded_set = 1'b1;
                    next_state = IDLE;
`endif
                end else begin
                    k_inc      = 1'b1;
                    next_state = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (bus.i_byte_valid) begin
                    if (bus.i_byte == csum) loaded_set = 1'b1;
                    else                    err_set    = 1'b1;
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Word assembly, write address/data registers and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word                <= '0;
            byte_cnt            <= '0;
            k                   <= '0;
            n                   <= '0;
            strobe_cnt          <= '0;
            loaded              <= 1'b0;
            o_error             <= 1'b0;
            bus.new_instruction <= '0;
            bus.final_pc        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum                <= '0;
`endif
        end else begin
            if (byte_shift) begin
                word     <= {bus.i_byte, word[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
            // Word and address are published on entry to WR_SETUP so they lead the strobe by a cycle.
            if (word_done) begin
                bus.new_instruction <= {bus.i_byte, word[31:8]};
                bus.final_pc        <= {{(RSIZE-8){1'b0}}, k};
            end
            if (k_clr) begin
                k        <= '0;
                byte_cnt <= '0;
            end else if (k_inc) begin
                k <= k + 8'd1;
            end
            if (n_load)          n <= bus.i_byte;
            if (strobe_clr)      strobe_cnt <= '0;
            else if (strobe_inc) strobe_cnt <= strobe_cnt + SCW'(1);
            if (err_set)         o_error <= 1'b1;
            else if (err_clr)    o_error <= 1'b0;
            if (loaded_clr)      loaded <= 1'b0;
            else if (loaded_set) loaded <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (csum_load)       csum <= bus.i_byte;
            else if (csum_xor)   csum <= csum ^ bus.i_byte;
`endif
        end
    end

    assign bus.new_instruction_available = (state == WR_STROBE);
    assign bus.execute                   = (state == RUN);
    assign o_busy                        = (state != IDLE) && (state != RUN);
endmodule

// File: tb/tb_simple22_loader.sv
// Directed self-checking bench for simple22_loader (IMEM_DEPTH=16, STROBE_CYCLES=4).
// Honours LOADER_CHECKSUM_EN when the build defines it.
module tb_simple22_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic o_busy, o_error;
    int   errors = 0;
    int   checks = 0;

    simple22_loader_if bus ();

    simple22_loader #(
        .IMEM_DEPTH    (16),
        .STROBE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .o_busy  (o_busy),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte is sampled at the posedge in between; returns at the following negedge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [23:0] pc, input logic [31:0] w);
        int hi;
        logic stable;
        send(b0);
        send(b1);
        send(b2);
        send(b3);
        chk("setup_strobe_low", {31'd0, bus.new_instruction_available}, 32'd0);
        chk("setup_pc", {8'd0, bus.final_pc}, {8'd0, pc});
        chk("setup_word", bus.new_instruction, w);
        chk("setup_busy", {31'd0, o_busy}, 32'd1);
        hi = 0;
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.new_instruction_available) begin
                hi++;
                if (bus.final_pc !== pc || bus.new_instruction !== w) stable = 1'b0;
            end
        end
        chk("strobe_width", hi, 32'd4);
        chk("strobe_stable", {31'd0, stable}, 32'd1);
    endtask

    initial begin
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_instr", bus.new_instruction, 32'd0);
        chk("rst_pc", {8'd0, bus.final_pc}, 32'd0);
        chk("rst_strobe", {31'd0, bus.new_instruction_available}, 32'd0);
        chk("rst_execute", {31'd0, bus.execute}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_error", {31'd0, o_error}, 32'd0);
        rst_n = 1'b1;

        // RUN with nothing loaded is refused
        send(8'h5A);
        chk("run_unloaded_err", {31'd0, o_error}, 32'd1);
        chk("run_unloaded_exec", {31'd0, bus.execute}, 32'd0);
        send(8'hA5);
        chk("load_clears_err", {31'd0, o_error}, 32'd0);
        chk("count_busy", {31'd0, o_busy}, 32'd1);

        // Two-word program
        send(8'h02);
        send_word(8'h78, 8'h56, 8'h34, 8'h12, 24'd0, 32'h12345678);
        send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 24'd1, 32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
        send(8'h28);
`endif
        chk("load_final_pc", {8'd0, bus.final_pc}, 32'd1);
        chk("load_done_busy", {31'd0, o_busy}, 32'd0);
        chk("load_no_err", {31'd0, o_error}, 32'd0);

        send(8'h5A);
        chk("run_exec", {31'd0, bus.execute}, 32'd1);
        send(8'h33);
        chk("run_ignore_byte", {31'd0, bus.execute}, 32'd1);
        send(8'hC3);
        chk("stop_exec", {31'd0, bus.execute}, 32'd0);

        // LOAD from RUN, then a zero count
        send(8'h5A);
        chk("rerun_exec", {31'd0, bus.execute}, 32'd1);
        send(8'hA5);
        chk("load_in_run_exec", {31'd0, bus.execute}, 32'd0);
        chk("load_in_run_busy", {31'd0, o_busy}, 32'd1);
        send(8'h00);
        chk("count0_err", {31'd0, o_error}, 32'd1);
        chk("count0_busy", {31'd0, o_busy}, 32'd0);
        send(8'h5A);
        chk("count0_no_run", {31'd0, bus.execute}, 32'd0);

        // Count one beyond IMEM_DEPTH
        send(8'hA5);
        chk("depth_clear_err", {31'd0, o_error}, 32'd0);
        send(8'd17);
        chk("depth_err", {31'd0, o_error}, 32'd1);
        chk("depth_no_strobe", {31'd0, bus.new_instruction_available}, 32'd0);
        chk("depth_busy", {31'd0, o_busy}, 32'd0);

        // Overrun during the strobe
        send(8'hA5);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        @(negedge clk);
        chk("ovr_strobe_high", {31'd0, bus.new_instruction_available}, 32'd1);
        send(8'h00);
        chk("ovr_strobe_drop", {31'd0, bus.new_instruction_available}, 32'd0);
        chk("ovr_err", {31'd0, o_error}, 32'd1);
        chk("ovr_busy", {31'd0, o_busy}, 32'd0);
        send(8'h5A);
        chk("ovr_no_run", {31'd0, bus.execute}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        send(8'hA5);
        send(8'h01);
        send_word(8'h01, 8'h02, 8'h03, 8'h04, 24'd0, 32'h04030201);
        send(8'h05);
        chk("csum_ok_err", {31'd0, o_error}, 32'd0);
        send(8'h5A);
        chk("csum_ok_run", {31'd0, bus.execute}, 32'd1);
        send(8'hC3);
        send(8'hA5);
        send(8'h01);
        send_word(8'h01, 8'h02, 8'h03, 8'h04, 24'd0, 32'h04030201);
        send(8'h06);
        chk("csum_bad_err", {31'd0, o_error}, 32'd1);
        send(8'h5A);
        chk("csum_bad_no_run", {31'd0, bus.execute}, 32'd0);
`endif

        // Asynchronous reset in the middle of DATA
        send(8'hA5);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        chk("mid_data_busy", {31'd0, o_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("async_rst_instr", bus.new_instruction, 32'd0);
        chk("async_rst_pc", {8'd0, bus.final_pc}, 32'd0);
        chk("async_rst_error", {31'd0, o_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h5A);
        chk("post_rst_unloaded", {31'd0, o_error}, 32'd1);
        chk("post_rst_no_run", {31'd0, bus.execute}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
